// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the four-source round-robin stream arbiter.
package rr_arb_pkg;

    localparam int unsigned N_SRC = 4;

    typedef logic [1:0] src_idx_t;

    // Next source index in rotation; the 2-bit add wraps 3 -> 0.
    function automatic src_idx_t next_idx(input src_idx_t idx);
        return idx + src_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority picker: first valid source at or after ptr.
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [N_SRC-1:0] valid,
    input  src_idx_t         ptr,
    output logic             found,
    output src_idx_t         grant
);

    // Scan offsets from farthest to nearest so the nearest valid source wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (valid[ptr + src_idx_t'(k)]) begin
                found = 1'b1;
                grant = ptr + src_idx_t'(k);
            end
        end
    end

endmodule

// File: rtl/rr_stream_arb_4.sv
// Four-input round-robin stream arbiter with a single registered output stage.
module rr_stream_arb_4
    import rr_arb_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] in_valid,
    input  logic [W-1:0]     in_data0,
    input  logic [W-1:0]     in_data1,
    input  logic [W-1:0]     in_data2,
    input  logic [W-1:0]     in_data3,
    output logic [N_SRC-1:0] in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);

    src_idx_t     ptr_q;
    logic         found;
    src_idx_t     grant;
    logic         load_en;
    logic         xfer;
    logic [W-1:0] data_arr [N_SRC];

    assign data_arr[0] = in_data0;
    assign data_arr[1] = in_data1;
    assign data_arr[2] = in_data2;
    assign data_arr[3] = in_data3;

    rr_pick_4 u_pick (
        .valid (in_valid),
        .ptr   (ptr_q),
        .found (found),
        .grant (grant)
    );

    // Output register can take a beat when empty or being drained this cycle.
    assign load_en = !out_valid || out_ready;
    assign xfer    = load_en && found;

    // One-hot accept for the granted source; nothing is accepted during reset.
    always_comb begin
        in_ready = '0;
        if (!rst && xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    // Output register and rotation pointer; pointer only moves on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr_q     <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= data_arr[grant];
            out_sel   <= grant;
            ptr_q     <= next_idx(grant);
        end else if (out_valid && out_ready) begin
            // Drained with nothing to replace it; data/sel keep last values.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_stream_arb_4.sv
// Self-checking bench for rr_stream_arb_4: vector table, corner sequences, random vs model.
module tb_rr_stream_arb_4;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_stream_arb_4 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic        o;
        logic [15:0] d;     // {d3,d2,d1,d0}
        logic [3:0]  rdy;   // in_ready before the edge
        logic        ov;    // outputs after the edge
        logic [1:0]  sel;
        logic [3:0]  dat;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic o,
                         input logic [15:0] d);
        rst       = r;
        in_valid  = v;
        out_ready = o;
        {in_data3, in_data2, in_data1, in_data0} = d;
    endtask

    // Check comb in_ready before the edge, then registered outputs after it.
    task automatic step(input string tag, input logic [3:0] erdy, input logic eov,
                        input logic [1:0] esel, input logic [3:0] edat);
        #1;
        chk({tag, " in_ready"}, 16'(in_ready), 16'(erdy));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 16'(out_valid), 16'(eov));
        chk({tag, " out_sel"}, 16'(out_sel), 16'(esel));
        chk({tag, " out_data"}, 16'(out_data), 16'(edat));
    endtask

    // Reference model state (plain integers, rotation by modulo arithmetic)
    int          m_ptr;
    logic        m_ov;
    int          m_sel;
    logic [3:0]  m_data;

    initial begin
        tbl[0]  = '{1'b1, 4'hF, 1'b1, 16'h4321, 4'b0000, 1'b0, 2'd0, 4'h0};
        tbl[1]  = '{1'b1, 4'hF, 1'b1, 16'h4321, 4'b0000, 1'b0, 2'd0, 4'h0};
        tbl[2]  = '{1'b0, 4'hF, 1'b1, 16'h4321, 4'b0001, 1'b1, 2'd0, 4'h1};
        tbl[3]  = '{1'b0, 4'hF, 1'b1, 16'h4321, 4'b0010, 1'b1, 2'd1, 4'h2};
        tbl[4]  = '{1'b0, 4'hF, 1'b1, 16'h4321, 4'b0100, 1'b1, 2'd2, 4'h3};
        tbl[5]  = '{1'b0, 4'hF, 1'b1, 16'h4321, 4'b1000, 1'b1, 2'd3, 4'h4};
        tbl[6]  = '{1'b0, 4'hF, 1'b1, 16'h4321, 4'b0001, 1'b1, 2'd0, 4'h1};
        tbl[7]  = '{1'b0, 4'h0, 1'b1, 16'h4321, 4'b0000, 1'b0, 2'd0, 4'h1};
        tbl[8]  = '{1'b0, 4'h4, 1'b1, 16'h4A21, 4'b0100, 1'b1, 2'd2, 4'hA};
        tbl[9]  = '{1'b0, 4'h5, 1'b1, 16'h4321, 4'b0001, 1'b1, 2'd0, 4'h1};
        tbl[10] = '{1'b0, 4'h5, 1'b1, 16'h4321, 4'b0100, 1'b1, 2'd2, 4'h3};
        tbl[11] = '{1'b0, 4'hA, 1'b0, 16'h4321, 4'b0000, 1'b1, 2'd2, 4'h3};
        tbl[12] = '{1'b0, 4'hA, 1'b1, 16'h4321, 4'b1000, 1'b1, 2'd3, 4'h4};
        tbl[13] = '{1'b0, 4'h0, 1'b0, 16'h4321, 4'b0000, 1'b1, 2'd3, 4'h4};
        tbl[14] = '{1'b0, 4'h2, 1'b1, 16'h4321, 4'b0010, 1'b1, 2'd1, 4'h2};

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].o, tbl[i].d);
            step($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].ov, tbl[i].sel, tbl[i].dat);
        end

        // Stall: held beat sel=1 with ptr=2; nothing may move for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'hF, 1'b0, 16'h4321);
            step($sformatf("stall%0d", i), 4'b0000, 1'b1, 2'd1, 4'h2);
        end
        // Release: drain and load in the same cycle, then rotation continues.
        drive(1'b0, 4'hF, 1'b1, 16'h4321);
        step("drain_load", 4'b0100, 1'b1, 2'd2, 4'h3);
        step("after_stall", 4'b1000, 1'b1, 2'd3, 4'h4);
        step("pre_rst", 4'b0001, 1'b1, 2'd0, 4'h1);
        // Reset with a held beat and full demand; ptr=1 before, must return to 0.
        drive(1'b1, 4'hF, 1'b1, 16'h4321);
        step("mid_rst", 4'b0000, 1'b0, 2'd0, 4'h0);
        drive(1'b0, 4'hF, 1'b1, 16'h4321);
        step("post_rst", 4'b0001, 1'b1, 2'd0, 4'h1);

        // Randomized run against the reference model.
        drive(1'b1, 4'h0, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        m_ptr  = 0;
        m_ov   = 1'b0;
        m_sel  = 0;
        m_data = 4'h0;
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic [3:0]  v;
            logic        o;
            logic [15:0] d;
            logic [3:0]  e_rdy;
            int          g;
            r = ($urandom_range(0, 31) == 0);
            v = 4'($urandom);
            o = ($urandom_range(0, 3) != 0);
            d = 16'($urandom);
            drive(r, v, o, d);

            g = -1;
            if (!r && (!m_ov || o)) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                end
            end
            e_rdy = 4'b0000;
            if (g >= 0) e_rdy[g] = 1'b1;

            #1;
            chk($sformatf("rnd%0d in_ready", n), 16'(in_ready), 16'(e_rdy));
            @(posedge clk);
            #1;
            if (r) begin
                m_ptr = 0; m_ov = 1'b0; m_sel = 0; m_data = 4'h0;
            end else if (g >= 0) begin
                m_ov   = 1'b1;
                m_sel  = g;
                m_data = d[g*4 +: 4];
                m_ptr  = (g + 1) % 4;
            end else if (m_ov && o) begin
                m_ov = 1'b0;
            end
            chk($sformatf("rnd%0d out_valid", n), 16'(out_valid), 16'(m_ov));
            chk($sformatf("rnd%0d out_sel", n), 16'(out_sel), 16'(m_sel));
            chk($sformatf("rnd%0d out_data", n), 16'(out_data), 16'(m_data));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
